trace_trig_seq: RTL

Trigger sequencer between the trace pattern matcher and the trigger output pin. It takes per-rule match pulses and runs an arm/fire/holdoff state machine that produces the capture trigger. It also keeps per-rule saturating match counters that feed the register block's trace-count readback. It runs in the trace clock domain; configuration inputs arrive already synchronized and are quasi-static.

---
 rtl/trace_defines.sv | 16 +
 rtl/trace_match_counter.sv | 35 +++
 rtl/trace_trig_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/trace_defines.sv
// Shared definitions for the trace trigger sequencer: FSM encodings and trigger-source IDs.
package trace_defines;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_FIRE    = 2'd2,
    ST_HOLDOFF = 2'd3
  } trig_state_e;

  // Reported in O_trig_rule when the soft trigger caused the fire
  localparam logic [3:0] SOFT_RULE_ID = 4'hF;

  localparam int DEF_TRIG_CYCLES = 4;

endpackage

// File: rtl/trace_match_counter.sv
// Single per-rule match counter: saturates at all-ones, synchronous clear wins over increment.
module trace_match_counter #(
  parameter int pCOUNT_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    inc_i,
  output logic [pCOUNT_WIDTH-1:0] count_o
);

  localparam logic [pCOUNT_WIDTH-1:0] ONE = pCOUNT_WIDTH'(1);

  logic [pCOUNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/trace_trig_seq.sv
// Trace trigger sequencer: arm/fire/holdoff FSM driving the capture trigger,
// plus per-rule saturating match counters for trace-count readback.
module trace_trig_seq
  import trace_defines::*;
#(
  parameter int pMATCH_RULES   = 8,
  parameter int pCOUNT_WIDTH   = 8,
  parameter int pTRIG_CYCLES   = DEF_TRIG_CYCLES,
  parameter int pHOLDOFF_WIDTH = 16
) (
  input  logic                                 trace_clk,
  input  logic                                 reset_n,
  input  logic [pMATCH_RULES-1:0]              I_matched,
  input  logic                                 I_synchronized,
  input  logic [pMATCH_RULES-1:0]              I_pattern_enable,
  input  logic [pMATCH_RULES-1:0]              I_pattern_trig_enable,
  input  logic                                 I_soft_trig,
  input  logic                                 I_soft_trig_passthru,
  input  logic                                 I_soft_trig_enable,
  input  logic                                 I_arm,
  input  logic                                 I_disarm,
  input  logic                                 I_auto_rearm,
  input  logic [pHOLDOFF_WIDTH-1:0]            I_holdoff,
  input  logic                                 I_count_clear,
  output logic                                 O_trigger,
  output logic                                 O_armed,
  output logic                                 O_busy,
  output logic [3:0]                           O_trig_rule,
  output logic [15:0]                          O_fire_count,
  output logic [pMATCH_RULES*pCOUNT_WIDTH-1:0] O_trace_count
);

  localparam int PW = (pTRIG_CYCLES > 1) ? $clog2(pTRIG_CYCLES) : 1;
  localparam logic [PW-1:0]             PULSE_LAST = PW'(pTRIG_CYCLES - 1);
  localparam logic [PW-1:0]             PULSE_ONE  = PW'(1);
  localparam logic [pHOLDOFF_WIDTH-1:0] HOLD_ONE   = pHOLDOFF_WIDTH'(1);

  trig_state_e               state_q, state_d;
  logic [PW-1:0]             pulse_q, pulse_d;
  logic [pHOLDOFF_WIDTH-1:0] hold_q, hold_d;
  logic                      soft_q;
  logic                      trig_q, trig_d;
  logic                      armed_q, armed_d;
  logic                      busy_q, busy_d;
  logic [3:0]                rule_q, rule_d;
  logic [15:0]               fire_cnt_q, fire_cnt_d;

  logic [pMATCH_RULES-1:0] qual;
  logic [pMATCH_RULES-1:0] rule_hits;
  logic                    rule_evt;
  logic                    soft_evt;
  logic                    trig_evt;
  logic [3:0]              rule_idx;

  assign qual      = I_matched & {pMATCH_RULES{I_synchronized}};
  assign rule_hits = qual & I_pattern_trig_enable;
  assign rule_evt  = |rule_hits;
  assign soft_evt  = I_soft_trig & ~soft_q & I_soft_trig_enable & ~I_soft_trig_passthru;
  assign trig_evt  = rule_evt | soft_evt;

  // Lowest firing rule wins; falls back to the soft ID when no rule fired
  always_comb begin
    rule_idx = SOFT_RULE_ID;
    for (int i = pMATCH_RULES - 1; i >= 0; i--) begin
      if (rule_hits[i]) rule_idx = 4'(i);
    end
  end

  always_ff @(posedge trace_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pulse_q    <= '0;
      hold_q     <= '0;
      soft_q     <= 1'b0;
      trig_q     <= 1'b0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      rule_q     <= '0;
      fire_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pulse_q    <= pulse_d;
      hold_q     <= hold_d;
      soft_q     <= I_soft_trig;
      trig_q     <= trig_d;
      armed_q    <= armed_d;
      busy_q     <= busy_d;
      rule_q     <= rule_d;
      fire_cnt_q <= fire_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pulse_d    = pulse_q;
    hold_d     = hold_q;
    rule_d     = rule_q;
    fire_cnt_d = fire_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (I_arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (trig_evt && !I_disarm) begin
          state_d    = ST_FIRE;
          pulse_d    = '0;
          rule_d     = rule_idx;
          fire_cnt_d = fire_cnt_q + 16'd1;
        end
      end
      ST_FIRE: begin
        if (pulse_q == PULSE_LAST) begin
          if (I_holdoff == '0) begin
            state_d = I_auto_rearm ? ST_ARMED : ST_IDLE;
          end else begin
            state_d = ST_HOLDOFF;
            hold_d  = I_holdoff;
          end
        end else begin
          pulse_d = pulse_q + PULSE_ONE;
        end
      end
      ST_HOLDOFF: begin
        if (hold_q <= HOLD_ONE) begin
          state_d = I_auto_rearm ? ST_ARMED : ST_IDLE;
        end else begin
          hold_d = hold_q - HOLD_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (I_disarm) state_d = ST_IDLE;
  end

  // Outputs are decoded from the next state so they register alongside it
  always_comb begin
    trig_d  = I_soft_trig_passthru ? I_soft_trig : (state_d == ST_FIRE);
    armed_d = (state_d == ST_ARMED);
    busy_d  = (state_d == ST_FIRE) || (state_d == ST_HOLDOFF);
  end

  assign O_trigger    = trig_q;
  assign O_armed      = armed_q;
  assign O_busy       = busy_q;
  assign O_trig_rule  = rule_q;
  assign O_fire_count = fire_cnt_q;

  for (genvar g = 0; g < pMATCH_RULES; g++) begin : g_cnt
    trace_match_counter #(
      .pCOUNT_WIDTH(pCOUNT_WIDTH)
    ) u_cnt (
      .clk_i  (trace_clk),
      .rst_ni (reset_n),
      .clear_i(I_count_clear),
      .inc_i  (qual[g] & I_pattern_enable[g]),
      .count_o(O_trace_count[g*pCOUNT_WIDTH +: pCOUNT_WIDTH])
    );
  end

endmodule
